pong_game_engine: RTL and testbench
===================================

Name: pong_game_engine

Overview:
Game-state engine that sits directly upstream of the VGA sync/render block. It computes ball position, paddle positions and scores once per video frame, and drives the render block's bola_x, bola_y, barra_e_y and barra_d_y inputs. Frame timing comes from the render block's VSync output, so positions change only during vertical sync and are stable across the visible area.

Parameters:
BALL_SPEED, 2, ball pixels per frame on each axis
PAD_SPEED, 4, paddle pixels per frame
POINT_FRAMES, 60, frames held in POINT state before the next serve
MAX_SCORE, 9, score that ends the game

Ports:
Clock  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
VSync  input  1  vertical sync from the render block, asynchronous to this logic
start  input  1  serve / restart request, active-high
btn_e_up  input  1  left paddle up, active-high
btn_e_down  input  1  left paddle down, active-high
btn_d_up  input  1  right paddle up, active-high
btn_d_down  input  1  right paddle down, active-high
bola_x  output  10  ball left edge x
bola_y  output  10  ball top edge y
barra_e_y  output  10  left paddle top y
barra_d_y  output  10  right paddle top y
placar_e  output  4  left score
placar_d  output  4  right score
estado  output  2  SERVE=0, PLAY=1, POINT=2, GAME_OVER=3

Behaviour:
- Clock is the only clock. Reset_n is asynchronous and active-low. While reset is asserted: bola_x=310, bola_y=230, barra_e_y=200, barra_d_y=200, scores 0, estado=SERVE, ball direction right+down, frame counter 0.
- Reset asserted mid-operation forces all outputs to their reset values immediately, with no frame wait.
- Frame tick generation:
  - VSync and all buttons pass through a 2-flop synchronizer; start also does.
  - tick = synchronized VSync high AND its previous registered value low.
  - All state updates occur only on the tick cycle. Outputs change on the 3rd Clock rising edge after VSync is first sampled high. Outputs are constant between ticks.
- Geometry constants: screen 640x480; top wall rows 0..5 (Y_MIN=6); Y_MAX_BALL=460 (480-20); ball 20x20; paddle 15 wide, 80 tall; left paddle face at X=16; right paddle x=630, ball-stop X=610; paddle Y range 6..400.
- Paddles, every tick, in all states:
  - up only: y = max(y-PAD_SPEED, 6).
  - down only: y = min(y+PAD_SPEED, 400).
  - both or neither: hold.
  - Compute in 11 bits so saturation never wraps.
- SERVE:
  - Ball held at (310,230).
  - start on a tick -> PLAY. Direction: rightwards after reset; otherwise toward the player who conceded the last point. Vertical direction is unchanged.
- PLAY, per tick:
  - y: nxt = y ± BALL_SPEED. If moving down and nxt >= 460: y=460, reverse. If moving up and nxt <= 6: y=6, reverse.
  - x, moving left: if x-BALL_SPEED <= 16, test overlap with the left paddle (bola_y+20 > barra_e_y AND bola_y < barra_e_y+80, using pre-update values).
    - Hit: x=16, direction right.
    - Miss: placar_d+1, state -> POINT.
  - x, moving right: mirror of the left case, with limit 610, x=610 on a hit, placar_e+1 on a miss.
  - A wall bounce and a paddle bounce in the same tick are both applied; the axes are independent.
  - All arithmetic uses 11-bit signed intermediates.
- POINT:
  - Ball frozen; frame counter increments per tick.
  - On reaching POINT_FRAMES-1: if either score == MAX_SCORE -> GAME_OVER, else -> SERVE with the ball recentred. Counter clears.
- GAME_OVER:
  - Ball frozen; scores held.
  - start on a tick -> scores 0, ball recentred, SERVE.
- start is ignored in PLAY and POINT. Scores saturate at MAX_SCORE and never wrap.

Decomposition:
- Package pong_pkg holds: screen and wall constants (H_VIS=640, V_VIS=480, Y_MIN=6), sprite sizes (ball 20, paddle 15x80), paddle x positions (0, 630), serve point (310,230), and the estado encoding.
- One sub-module, pong_paddle, is instantiated twice. Ports: Clock, Reset_n, tick, up, down -> y. It contains the button synchronizers and the saturating update.

Test Plan:
- Reset, then 3 VSync pulses with no input -> outputs stay (310,230), paddles at 200, estado=0, scores 0.
- Assert btn_e_up for 60 frames from y=200 -> barra_e_y = 200-4k, saturating at 6 by frame 49 and holding. Both buttons on the right paddle -> barra_d_y unchanged.
- start, then track ball frames -> per frame x+2, y+2. At bola_y 458 -> next frame 460, after which y decreases. Outputs change exactly 3 Clock cycles after the VSync rise.
- Ball moving left with barra_e_y=200 and bola_y=230 reaching x<=18 -> x=16 and moves right. With barra_e_y=6 and bola_y=230 instead -> placar_d=1, estado=2, then after 60 frames estado=0, ball at (310,230), next serve leftwards.
- Force placar_e=8 and miss on the right -> placar_e=9, POINT, then estado=3. start -> scores 0, estado=0.
- Assert Reset_n low mid-PLAY, between ticks -> all outputs at reset values in the same cycle, without waiting for VSync.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared constants, types and helpers for the pong game engine.
//   Screen/wall geometry, sprite sizes, paddle x positions, serve point,
//   estado encoding, ball state struct and 11-bit signed coordinate helpers.
package pong_pkg;

  localparam int H_VIS      = 640;
  localparam int V_VIS      = 480;
  localparam int Y_MIN      = 6;                 // first row below the top wall
  localparam int BALL_SZ    = 20;
  localparam int PAD_W      = 15;
  localparam int PAD_H      = 80;
  localparam int PAD_E_X    = 0;
  localparam int PAD_D_X    = 630;
  localparam int X_MIN_BALL = 16;                // left paddle face
  localparam int X_MAX_BALL = PAD_D_X - BALL_SZ; // 610, ball stops at right paddle
  localparam int Y_MAX_BALL = V_VIS - BALL_SZ;   // 460
  localparam int PAD_Y_MAX  = V_VIS - PAD_H;     // 400
  localparam int PAD_Y_RST  = 200;
  localparam int SERVE_X    = 310;
  localparam int SERVE_Y    = 230;

  localparam int COORD_W    = 10;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W:0]   scoord_t;  // one extra bit so +/- never wraps

  typedef enum logic [1:0] {
    ST_SERVE     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_POINT     = 2'd2,
    ST_GAME_OVER = 2'd3
  } estado_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   dir_r;   // 1 = moving right
    logic   dir_d;   // 1 = moving down
  } ball_t;

  function automatic scoord_t to_s(coord_t v);
    return $signed({1'b0, v});
  endfunction

  function automatic scoord_t sc(int v);
    return scoord_t'(v);
  endfunction

endpackage

// File: rtl/pong_game_engine_if.sv
// pong_game_engine_if: game inputs (VSync, start, paddle buttons) and the
// render-side outputs (ball/paddle positions, scores, estado).
//   master : stimulus side, drives inputs and observes outputs
//   slave  : the engine
interface pong_game_engine_if;
  import pong_pkg::*;

  logic       VSync;
  logic       start;
  logic       btn_e_up;
  logic       btn_e_down;
  logic       btn_d_up;
  logic       btn_d_down;
  coord_t     bola_x;
  coord_t     bola_y;
  coord_t     barra_e_y;
  coord_t     barra_d_y;
  logic [3:0] placar_e;
  logic [3:0] placar_d;
  logic [1:0] estado;

  modport master (
    output VSync, start, btn_e_up, btn_e_down, btn_d_up, btn_d_down,
    input  bola_x, bola_y, barra_e_y, barra_d_y, placar_e, placar_d, estado
  );

  modport slave (
    input  VSync, start, btn_e_up, btn_e_down, btn_d_up, btn_d_down,
    output bola_x, bola_y, barra_e_y, barra_d_y, placar_e, placar_d, estado
  );

endinterface

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's vertical position.
//   Clock, Reset_n : clock, async active-low reset
//   tick           : one-cycle frame strobe; y only moves on it
//   up, down       : raw button inputs, synchronized here
//   y              : paddle top row, saturating in [Y_MIN, PAD_Y_MAX]
module pong_paddle
  import pong_pkg::*;
#(
  parameter int PAD_SPEED = 4
) (
  input  logic   Clock,
  input  logic   Reset_n,
  input  logic   tick,
  input  logic   up,
  input  logic   down,
  output coord_t y
);

  logic [1:0] up_pipe, dn_pipe;
  scoord_t    ys, y_up, y_dn;
  coord_t     y_nxt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      up_pipe <= '0;
      dn_pipe <= '0;
    end else begin
      up_pipe <= {up_pipe[0], up};
      dn_pipe <= {dn_pipe[0], down};
    end
  end

  // Both or neither button held: paddle stays put.
  always_comb begin
    ys    = to_s(y);
    y_up  = ys - sc(PAD_SPEED);
    y_dn  = ys + sc(PAD_SPEED);
    y_nxt = y;
    if (up_pipe[1] && !dn_pipe[1])
      y_nxt = (y_up < sc(Y_MIN)) ? coord_t'(Y_MIN) : coord_t'(y_up);
    else if (dn_pipe[1] && !up_pipe[1])
      y_nxt = (y_dn > sc(PAD_Y_MAX)) ? coord_t'(PAD_Y_MAX) : coord_t'(y_dn);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)  y <= coord_t'(PAD_Y_RST);
    else if (tick) y <= y_nxt;
  end

endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine: per-frame pong state (ball, paddles, scores, game state).
//   Clock, Reset_n : system clock, async active-low reset
//   bus (slave)    : VSync/start/buttons in; bola_x/bola_y, barra_e_y/barra_d_y,
//                    placar_e/placar_d, estado out
// All state moves on a single-cycle tick derived from the rising edge of the
// synchronized VSync, so outputs are stable through the visible area.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int POINT_FRAMES = 60,
  parameter int MAX_SCORE    = 9
) (
  input  logic Clock,
  input  logic Reset_n,
  pong_game_engine_if.slave bus
);

  localparam int NUM_PAD = 2;  // 0 = left (e), 1 = right (d)
  localparam int CNT_W   = $clog2(POINT_FRAMES + 1);

  // ---------------- frame tick / start sync ----------------
  // vs_pipe[1:0] is the 2-flop synchronizer, vs_pipe[2] the previous value.
  logic [2:0] vs_pipe;
  logic [1:0] start_pipe;
  logic       tick, start_s;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_pipe    <= '0;
      start_pipe <= '0;
    end else begin
      vs_pipe    <= {vs_pipe[1:0], bus.VSync};
      start_pipe <= {start_pipe[0], bus.start};
    end
  end

  assign tick    = vs_pipe[1] & ~vs_pipe[2];
  assign start_s = start_pipe[1];

  // ---------------- paddles ----------------
  logic [NUM_PAD-1:0]              pad_up, pad_dn;
  logic [NUM_PAD-1:0][COORD_W-1:0] pad_y;

  assign pad_up = {bus.btn_d_up,   bus.btn_e_up};
  assign pad_dn = {bus.btn_d_down, bus.btn_e_down};

  for (genvar p = 0; p < NUM_PAD; p++) begin : g_pad
    pong_paddle #(.PAD_SPEED(PAD_SPEED)) u_pad (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .tick    (tick),
      .up      (pad_up[p]),
      .down    (pad_dn[p]),
      .y       (pad_y[p])
    );
  end

  // ---------------- game state ----------------
  estado_t          state, state_nxt;
  ball_t            ball, ball_nxt;
  logic [3:0]       score_e, score_d, score_e_nxt, score_d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  scoord_t bx, by, pe, pd, x_nxt, y_nxt;
  logic    y_bounce, at_e, at_d, hit_e, hit_d, miss_e, miss_d;
  logic    cnt_done, game_end;

  // Play-field evaluation; paddle overlap uses pre-update ball and paddle y.
  always_comb begin
    bx       = to_s(ball.x);
    by       = to_s(ball.y);
    pe       = to_s(pad_y[0]);
    pd       = to_s(pad_y[1]);
    y_nxt    = ball.dir_d ? by + sc(BALL_SPEED) : by - sc(BALL_SPEED);
    y_bounce = ball.dir_d ? (y_nxt >= sc(Y_MAX_BALL)) : (y_nxt <= sc(Y_MIN));
    x_nxt    = ball.dir_r ? bx + sc(BALL_SPEED) : bx - sc(BALL_SPEED);
    at_e     = !ball.dir_r && (x_nxt <= sc(X_MIN_BALL));
    at_d     =  ball.dir_r && (x_nxt >= sc(X_MAX_BALL));
    hit_e    = (by + sc(BALL_SZ) > pe) && (by < pe + sc(PAD_H));
    hit_d    = (by + sc(BALL_SZ) > pd) && (by < pd + sc(PAD_H));
    miss_e   = at_e && !hit_e;
    miss_d   = at_d && !hit_d;
    cnt_done = (cnt == CNT_W'(POINT_FRAMES - 1));
    game_end = (score_e == 4'(MAX_SCORE)) || (score_d == 4'(MAX_SCORE));
  end

  // FSM: state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= ST_SERVE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        ST_SERVE:     if (start_s) state_nxt = ST_PLAY;
        ST_PLAY:      if (miss_e || miss_d) state_nxt = ST_POINT;
        ST_POINT:     if (cnt_done) state_nxt = game_end ? ST_GAME_OVER : ST_SERVE;
        ST_GAME_OVER: if (start_s) state_nxt = ST_SERVE;
        default:      state_nxt = ST_SERVE;
      endcase
    end
  end

  // FSM: datapath outputs. Serve direction needs no extra state: a miss leaves
  // dir_r pointing at the player who conceded, which is where the next serve goes.
  always_comb begin
    ball_nxt    = ball;
    score_e_nxt = score_e;
    score_d_nxt = score_d;
    cnt_nxt     = cnt;
    if (tick) begin
      case (state)
        ST_PLAY: begin
          if (y_bounce) begin
            ball_nxt.y     = ball.dir_d ? coord_t'(Y_MAX_BALL) : coord_t'(Y_MIN);
            ball_nxt.dir_d = ~ball.dir_d;
          end else begin
            ball_nxt.y = coord_t'(y_nxt);
          end
          if (at_e) begin
            if (hit_e) begin
              ball_nxt.x     = coord_t'(X_MIN_BALL);
              ball_nxt.dir_r = 1'b1;
            end else if (score_d != 4'(MAX_SCORE)) begin
              score_d_nxt = score_d + 4'd1;
            end
          end else if (at_d) begin
            if (hit_d) begin
              ball_nxt.x     = coord_t'(X_MAX_BALL);
              ball_nxt.dir_r = 1'b0;
            end else if (score_e != 4'(MAX_SCORE)) begin
              score_e_nxt = score_e + 4'd1;
            end
          end else begin
            ball_nxt.x = coord_t'(x_nxt);
          end
        end
        ST_POINT: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_done) begin
            cnt_nxt = '0;
            if (!game_end) begin
              ball_nxt.x = coord_t'(SERVE_X);
              ball_nxt.y = coord_t'(SERVE_Y);
            end
          end
        end
        ST_GAME_OVER: begin
          if (start_s) begin
            score_e_nxt = '0;
            score_d_nxt = '0;
            ball_nxt.x  = coord_t'(SERVE_X);
            ball_nxt.y  = coord_t'(SERVE_Y);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ball    <= '{x: coord_t'(SERVE_X), y: coord_t'(SERVE_Y), dir_r: 1'b1, dir_d: 1'b1};
      score_e <= '0;
      score_d <= '0;
      cnt     <= '0;
    end else begin
      ball    <= ball_nxt;
      score_e <= score_e_nxt;
      score_d <= score_d_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.bola_x    = ball.x;
  assign bus.bola_y    = ball.y;
  assign bus.barra_e_y = pad_y[0];
  assign bus.barra_d_y = pad_y[1];
  assign bus.placar_e  = score_e;
  assign bus.placar_d  = score_d;
  assign bus.estado    = state;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: frame-level reference model of the game rules, compared
// against the engine on every falling clock edge, plus literal anchor checks.
module tb_pong_game_engine;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  pong_game_engine_if bus();

  pong_game_engine dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state (one update per frame)
  int m_bx, m_by, m_pe, m_pd, m_se, m_sd, m_st, m_pt;
  bit m_right, m_down;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 310; m_by = 230; m_pe = 200; m_pd = 200;
    m_se = 0;   m_sd = 0;   m_st = 0;   m_pt = 0;
    m_right = 1'b1; m_down = 1'b1;
  endtask

  function automatic int pad_move(int y, bit up, bit dn);
    if (up && !dn) return (y - 4 < 6) ? 6 : y - 4;
    if (dn && !up) return (y + 4 > 400) ? 400 : y + 4;
    return y;
  endfunction

  task automatic model_step();
    int ne, nd, nx, ny;
    ne = pad_move(m_pe, bus.btn_e_up, bus.btn_e_down);
    nd = pad_move(m_pd, bus.btn_d_up, bus.btn_d_down);
    case (m_st)
      0: if (bus.start) m_st = 1;
      1: begin
        ny = m_down ? m_by + 2 : m_by - 2;
        if (m_down && ny >= 460)      begin ny = 460; m_down = 1'b0; end
        else if (!m_down && ny <= 6)  begin ny = 6;   m_down = 1'b1; end
        nx = m_right ? m_bx + 2 : m_bx - 2;
        if (!m_right && nx <= 16) begin
          if (m_by + 20 > m_pe && m_by < m_pe + 80) begin m_bx = 16; m_right = 1'b1; end
          else begin m_sd = (m_sd < 9) ? m_sd + 1 : 9; m_st = 2; end
        end else if (m_right && nx >= 610) begin
          if (m_by + 20 > m_pd && m_by < m_pd + 80) begin m_bx = 610; m_right = 1'b0; end
          else begin m_se = (m_se < 9) ? m_se + 1 : 9; m_st = 2; end
        end else begin
          m_bx = nx;
        end
        m_by = ny;
      end
      2: begin
        m_pt++;
        if (m_pt == 60) begin
          m_pt = 0;
          if (m_se == 9 || m_sd == 9) m_st = 3;
          else begin m_st = 0; m_bx = 310; m_by = 230; end
        end
      end
      default: if (bus.start) begin
        m_se = 0; m_sd = 0; m_bx = 310; m_by = 230; m_st = 0;
      end
    endcase
    m_pe = ne;
    m_pd = nd;
  endtask

  // One video frame: inputs already set by the caller stay steady; VSync rises
  // just after an edge, and the update lands on the 3rd rising edge after that.
  task automatic frame();
    repeat (2) @(posedge Clock);
    #1 bus.VSync = 1'b1;
    repeat (3) @(posedge Clock);
    #1 model_step();
    bus.VSync = 1'b0;
  endtask

  task automatic set_btn(bit eu, bit ed, bit du, bit dd);
    bus.btn_e_up = eu; bus.btn_e_down = ed;
    bus.btn_d_up = du; bus.btn_d_down = dd;
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      checks++;
      if (bus.bola_x !== 10'(m_bx) || bus.bola_y !== 10'(m_by) ||
          bus.barra_e_y !== 10'(m_pe) || bus.barra_d_y !== 10'(m_pd) ||
          bus.placar_e !== 4'(m_se) || bus.placar_d !== 4'(m_sd) ||
          bus.estado !== 2'(m_st)) begin
        errors++;
        $display("FAIL model_cmp t=%0t dut(x=%0d y=%0d e=%0d d=%0d se=%0d sd=%0d st=%0d) model(x=%0d y=%0d e=%0d d=%0d se=%0d sd=%0d st=%0d)",
                 $time, bus.bola_x, bus.bola_y, bus.barra_e_y, bus.barra_d_y,
                 bus.placar_e, bus.placar_d, bus.estado,
                 m_bx, m_by, m_pe, m_pd, m_se, m_sd, m_st);
      end
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_x"},  int'(bus.bola_x), 310);
    chk({tag, "_y"},  int'(bus.bola_y), 230);
    chk({tag, "_pe"}, int'(bus.barra_e_y), 200);
    chk({tag, "_pd"}, int'(bus.barra_d_y), 200);
    chk({tag, "_se"}, int'(bus.placar_e), 0);
    chk({tag, "_sd"}, int'(bus.placar_d), 0);
    chk({tag, "_st"}, int'(bus.estado), 0);
  endtask

  initial begin
    int n;
    bus.VSync = 1'b0; bus.start = 1'b0;
    set_btn(0, 0, 0, 0);
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge Clock);
    #1 chk_reset_vals("reset");
    Reset_n = 1'b1;

    // idle frames: nothing moves
    repeat (3) frame();
    chk_reset_vals("idle");

    // left up for 60 frames, right both buttons
    set_btn(1, 0, 1, 1);
    for (int k = 1; k <= 60; k++) begin
      frame();
      if (k == 10) chk("pad_e_k10", int'(bus.barra_e_y), 160);
      if (k == 48) chk("pad_e_k48", int'(bus.barra_e_y), 8);
      if (k == 49) chk("pad_e_k49", int'(bus.barra_e_y), 6);
    end
    chk("pad_e_k60", int'(bus.barra_e_y), 6);
    chk("pad_d_both", int'(bus.barra_d_y), 200);
    set_btn(0, 0, 0, 0);

    // serve and track the ball
    bus.start = 1'b1;
    frame();
    chk("serve_st", int'(bus.estado), 1);
    chk("serve_x", int'(bus.bola_x), 310);
    bus.start = 1'b0;
    frame();
    chk("play1_x", int'(bus.bola_x), 312);
    chk("play1_y", int'(bus.bola_y), 232);
    repeat (113) frame();
    chk("play114_y", int'(bus.bola_y), 458);
    frame();
    chk("play115_y", int'(bus.bola_y), 460);
    chk("play115_x", int'(bus.bola_x), 540);
    frame();
    chk("play116_y", int'(bus.bola_y), 458);

    // right paddle at 200 misses the ball at y=392
    n = 0;
    while (m_st == 1 && n < 200) begin frame(); n++; end
    chk("miss_frames", n, 34);
    chk("miss_se", int'(bus.placar_e), 1);
    chk("miss_st", int'(bus.estado), 2);
    chk("miss_x", int'(bus.bola_x), 608);
    repeat (59) frame();
    chk("point59_st", int'(bus.estado), 2);
    frame();
    chk("point60_st", int'(bus.estado), 0);
    chk("point60_x", int'(bus.bola_x), 310);
    chk("point60_y", int'(bus.bola_y), 230);

    // random play
    for (int k = 0; k < 500; k++) begin
      set_btn($urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      bus.start = ($urandom_range(0, 7) == 0);
      if (m_st == 3) bus.start = 1'b0;
      frame();
    end

    // left paddle dodges, right paddle tracks: drives the game to its end
    n = 0;
    bus.start = 1'b1;
    while (m_st != 3 && n < 5000) begin
      set_btn(m_by + 10 >= m_pe + 40, m_by + 10 < m_pe + 40,
              m_pd + 40 > m_by + 10,  m_pd + 40 < m_by + 10);
      frame();
      n++;
    end
    bus.start = 1'b0;
    set_btn(0, 0, 0, 0);
    chk("reach_game_over", m_st, 3);
    chk("go_st", int'(bus.estado), 3);
    chk("go_max", int'(bus.placar_e == 4'd9 || bus.placar_d == 4'd9), 1);
    frame();
    chk("go_hold", int'(bus.estado), 3);
    bus.start = 1'b1;
    frame();
    bus.start = 1'b0;
    chk("restart_st", int'(bus.estado), 0);
    chk("restart_se", int'(bus.placar_e), 0);
    chk("restart_sd", int'(bus.placar_d), 0);
    chk("restart_x", int'(bus.bola_x), 310);

    // reset mid-play, between ticks
    bus.start = 1'b1;
    frame();
    bus.start = 1'b0;
    set_btn(0, 1, 1, 0);
    repeat (20) frame();
    chk("pre_rst_st", int'(bus.estado), 1);
    @(posedge Clock);
    #3 Reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
    set_btn(0, 0, 0, 0);
    repeat (2) frame();

    @(posedge Clock);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
